// File: rtl/instr_decode.sv
// PDP-8 style instruction fetch/decode front end. Fetches the word at PC,
// resolves one level of indirection for memory-reference instructions, and
// presents a one-hot opcode plus effective address to the execute unit until
// it drops stall.

package instr_decode_pkg;

    typedef struct packed {
        logic and_op;
        logic tad;
        logic isz;
        logic dca;
        logic jms;
        logic jmp;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic nop;
        logic iac;
        logic ral;
        logic rtl;
        logic rar;
        logic rtr;
        logic cml;
        logic cma;
        logic cia;
        logic cll;
        logic cla;
        logic cla_cll;
    } pdp_op7_opcode_s;

endpackage

// state      | meaning
// IDLE       | post-reset holding cycle
// FETCH      | read request at PC_value
// INSTR_WAIT | instruction word returning, captured into ir
// DECODE     | fields decoded; direct ops/address loaded or indirection started
// IND_REQ    | read request at the direct address (pointer fetch)
// IND_WAIT   | pointer returning, loaded as base_addr
// DISPATCH   | outputs presented, waiting for execute to raise stall
// EXEC_WAIT  | outputs held while stall=1; cleared when it falls
module instr_decode
    import instr_decode_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    output logic                  ifu_rd_req,
    output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output pdp_mem_opcode_s       pdp_mem_opcode,
    output pdp_op7_opcode_s       pdp_op7_opcode
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        INSTR_WAIT,
        DECODE,
        IND_REQ,
        IND_WAIT,
        DISPATCH,
        EXEC_WAIT
    } state_e;

    state_e                state;
    state_e                state_next;
    logic [DATA_WIDTH-1:0] ir;

    logic                  load_ir;
    logic                  load_direct;
    logic                  load_indirect;
    logic                  clear_out;

    logic [2:0]            opcode;
    logic                  is_mem_ref;
    logic [ADDR_WIDTH-1:0] direct_addr;
    pdp_mem_opcode_s       mem_dec;
    pdp_op7_opcode_s       op7_dec;

    assign opcode     = ir[11:9];
    assign is_mem_ref = (opcode < 3'd6);
    // Z selects the current page (PC bits 11:7) instead of page zero.
    assign direct_addr = ir[7] ? {PC_value[11:7], ir[6:0]} : {5'b0, ir[6:0]};

    // Decode the instruction register into one-hot opcode structs; anything
    // not recognised leaves both structs zero.
    always_comb begin
        mem_dec = '0;
        op7_dec = '0;
        case (opcode)
            3'd0: mem_dec.and_op = 1'b1;
            3'd1: mem_dec.tad    = 1'b1;
            3'd2: mem_dec.isz    = 1'b1;
            3'd3: mem_dec.dca    = 1'b1;
            3'd4: mem_dec.jms    = 1'b1;
            3'd5: mem_dec.jmp    = 1'b1;
            3'd7: begin
                if (!ir[8]) begin
                    case (ir)
                        12'o7000: op7_dec.nop     = 1'b1;
                        12'o7001: op7_dec.iac     = 1'b1;
                        12'o7004: op7_dec.ral     = 1'b1;
                        12'o7006: op7_dec.rtl     = 1'b1;
                        12'o7010: op7_dec.rar     = 1'b1;
                        12'o7012: op7_dec.rtr     = 1'b1;
                        12'o7020: op7_dec.cml     = 1'b1;
                        12'o7040: op7_dec.cma     = 1'b1;
                        12'o7041: op7_dec.cia     = 1'b1;
                        12'o7100: op7_dec.cll     = 1'b1;
                        12'o7200: op7_dec.cla     = 1'b1;
                        12'o7300: op7_dec.cla_cll = 1'b1;
                        default:  ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, read-port drive and datapath load strobes.
    always_comb begin
        state_next    = state;
        ifu_rd_req    = 1'b0;
        ifu_rd_addr   = '0;
        load_ir       = 1'b0;
        load_direct   = 1'b0;
        load_indirect = 1'b0;
        clear_out     = 1'b0;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                ifu_rd_req  = 1'b1;
                ifu_rd_addr = PC_value;
                state_next  = INSTR_WAIT;
            end
            INSTR_WAIT: begin
                load_ir    = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                if (is_mem_ref && ir[8]) begin
                    state_next = IND_REQ;
                end else begin
                    load_direct = 1'b1;
                    state_next  = DISPATCH;
                end
            end
            IND_REQ: begin
                ifu_rd_req  = 1'b1;
                ifu_rd_addr = direct_addr;
                state_next  = IND_WAIT;
            end
            IND_WAIT: begin
                load_indirect = 1'b1;
                state_next    = DISPATCH;
            end
            DISPATCH: begin
                if (stall) begin
                    state_next = EXEC_WAIT;
                end
            end
            EXEC_WAIT: begin
                if (!stall) begin
                    clear_out  = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Instruction register and registered decode outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir             <= '0;
            base_addr      <= '0;
            pdp_mem_opcode <= '0;
            pdp_op7_opcode <= '0;
        end else begin
            if (load_ir) begin
                ir <= ifu_rd_data;
            end
            if (load_direct) begin
                pdp_mem_opcode <= mem_dec;
                pdp_op7_opcode <= op7_dec;
                base_addr      <= is_mem_ref ? direct_addr : '0;
            end else if (load_indirect) begin
                pdp_mem_opcode <= mem_dec;
                pdp_op7_opcode <= '0;
                base_addr      <= ifu_rd_data;
            end else if (clear_out) begin
                pdp_mem_opcode <= '0;
                pdp_op7_opcode <= '0;
                base_addr      <= '0;
            end
        end
    end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have port clk, input, 1 bit: free-running clock; all state updates on posedge clk.
REQ-002 SHALL have port reset_n, input, 1 bit: synchronous active-low reset, sampled on posedge clk.
REQ-003 SHALL have port stall, input, 1 bit: asserted by instr_exec while it executes the dispatched instruction.
REQ-004 SHALL have port PC_value, input, ADDR_WIDTH (12): current PC from instr_exec.
REQ-005 SHALL have port ifu_rd_req, output, 1 bit: memory read request, a single-cycle pulse.
REQ-006 SHALL have port ifu_rd_addr, output, 12 bits: read address, valid while ifu_rd_req=1.
REQ-007 SHALL have port ifu_rd_data, input, DATA_WIDTH (12): read data, valid exactly 1 cycle after ifu_rd_req.
REQ-008 SHALL have port base_addr, output, 12 bits: final effective address of a memory-reference instruction.
REQ-009 SHALL have port pdp_mem_opcode, output, pdp_mem_opcode_s: one-hot AND, TAD, ISZ, DCA, JMS, JMP.
REQ-010 SHALL have port pdp_op7_opcode, output, pdp_op7_opcode_s: one-hot group-1 OPR microinstructions.

Function
REQ-011 SHALL use an FSM with states IDLE, FETCH, INSTR_WAIT, DECODE, IND_REQ, IND_WAIT, DISPATCH, EXEC_WAIT.
REQ-012 SHALL transition IDLE->FETCH unconditionally, one cycle after reset_n is sampled high.
REQ-013 SHALL, in FETCH, assert ifu_rd_req=1 with ifu_rd_addr=PC_value sampled that cycle, then go to INSTR_WAIT.
REQ-014 SHALL, in INSTR_WAIT, capture ifu_rd_data into an internal 12-bit instruction register, then go to DECODE.
REQ-015 SHALL decode fields as follows: opcode=IR[11:9], I=IR[8], Z=IR[7], offset=IR[6:0].
REQ-016 SHALL form the direct address for opcodes 0-5 as {5'b0, offset} when Z=0 and {PC_value[11:7], offset} when Z=1.
REQ-017 SHALL, for a memory-reference instruction with I=0, load base_addr with the direct address and go DECODE->DISPATCH.
REQ-018 SHALL, for a memory-reference instruction with I=1, go to IND_REQ: assert ifu_rd_req with ifu_rd_addr=direct address; IND_WAIT then loads base_addr from ifu_rd_data and goes to DISPATCH.
REQ-019 SHALL perform no auto-increment for indirect addresses 0010-0017 (octal).
REQ-020 SHALL map opcodes 0/1/2/3/4/5 to AND/TAD/ISZ/DCA/JMS/JMP respectively.
REQ-021 SHALL decode opcode 7 with IR[8]=0 (group 1) by exact octal match: 7000 NOP, 7001 IAC, 7004 RAL, 7006 RTL, 7010 RAR, 7012 RTR, 7020 CML, 7040 CMA, 7041 CIA, 7100 CLL, 7200 CLA, 7300 CLA_CLL.
REQ-022 SHALL set base_addr=0 for all OPR encodings.
REQ-023 SHALL treat opcode 6 (IOT), group-2/3 OPR, and unmatched group-1 codes as unsupported: both opcode structs all-zero and base_addr=0, with the dispatch handshake still performed.
REQ-024 SHALL, in DISPATCH, drive exactly one opcode field (or none if unsupported) and base_addr, holding them stable; it SHALL go to EXEC_WAIT when stall=1.
REQ-025 SHALL hold outputs in EXEC_WAIT while stall=1; on the first cycle stall=0 it SHALL clear both structs and base_addr and go to FETCH.
REQ-026 SHALL issue no ifu_rd_req in DISPATCH or EXEC_WAIT.
REQ-027 SHALL never assert ifu_rd_req in two consecutive cycles.
REQ-028 SHALL ignore stall in all states other than DISPATCH and EXEC_WAIT.
REQ-029 SHALL, if stall is already 1 on entry to DISPATCH, go to EXEC_WAIT the next cycle.

Reset
REQ-030 SHALL, while reset_n=0 at posedge clk, force state to IDLE, ifu_rd_req=0, ifu_rd_addr=0, base_addr=0, IR=0, and all opcode fields to 0.
REQ-031 SHALL abort a reset asserted mid-operation (including between IND_REQ and IND_WAIT) and discard any returning read data.
REQ-032 SHALL start its first fetch at PC_value (START_ADDRESS) two cycles after reset_n rises.

Verification
REQ-033 SHALL pass: PC=0200, mem[0200]=1045 -> TAD=1, base_addr=0045, exactly one read.
REQ-034 SHALL pass: PC=0200, mem[0200]=1245 -> TAD=1, base_addr=0245.
REQ-035 SHALL pass: PC=0200, mem[0200]=5445, mem[0045]=3000 -> second read at 0045, then JMP=1, base_addr=3000.
REQ-036 SHALL pass: mem[PC]=7300 -> CLA_CLL=1, base_addr=0; outputs held through a 5-cycle stall, cleared when stall falls, next fetch at the updated PC_value.
REQ-037 SHALL pass: mem[PC]=6001 -> all opcode fields 0, handshake completes, next fetch issued.
REQ-038 SHALL pass: reset_n low for one cycle during IND_WAIT -> all outputs 0, stale data ignored, fetch restarts at START_ADDRESS.
